// File: rtl/spi_recv.sv
// spi_recv: SPI mode-0 slave receiver that oversamples SCLK/SS/MOSI on clk and deserializes MSB-first words.
// Define SPI_RECV_LEN_CHECK_EN to add len_err, flagging frames whose word count differs from P_FRAME_LEN.
module spi_recv #(
  parameter int P_DATA_IN_WIDTH   = 1,
  parameter int P_DATA_TEMP_WIDTH = 8,
  parameter int P_FRAME_LEN       = 3,
  parameter int P_SYNC_STAGES     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SPI0_SCLK_O,
  input  logic [P_DATA_IN_WIDTH-1:0]   SPI0_MOSI_O,
  input  logic                         SPI0_SS_O,
  output logic [P_DATA_TEMP_WIDTH-1:0] data_o,
  output logic                         data_valid,
  output logic [7:0]                   byte_cnt,
  output logic                         frame_done,
  output logic                         frame_err
`ifdef SPI_RECV_LEN_CHECK_EN
  ,
  output logic                         len_err
`endif
);

  localparam int W  = P_DATA_IN_WIDTH;
  localparam int T  = P_DATA_TEMP_WIDTH;
  localparam int BW = $clog2(T + 1);
  localparam int FW = $clog2(P_SYNC_STAGES + 1);

  typedef enum logic [1:0] { WAIT_IDLE, IDLE, ACTIVE, CLOSE } state_e;

  if (P_SYNC_STAGES < 2 || W < 1 || (T % W) != 0 || P_FRAME_LEN < 0 || P_FRAME_LEN > 255)
  begin : g_param_check
    $error("spi_recv: illegal parameter combination");
  end

  logic [P_SYNC_STAGES-1:0]        sclk_sync_q;
  logic [P_SYNC_STAGES-1:0]        ss_sync_q;
  logic [P_SYNC_STAGES-1:0][W-1:0] mosi_sync_q;
  logic                            sclk_prev_q;
  logic                            ss_prev_q;

  logic         sclk_s;
  logic         ss_s;
  logic [W-1:0] mosi_s;
  logic         sclk_rise;
  logic         ss_rise;
  logic         ss_fall;
  logic         word_full;

  state_e        state_q;
  logic [FW-1:0] flush_cnt_q;
  logic [BW-1:0] bit_cnt_q;
  logic [T-1:0]  shreg_q;
  logic [T-1:0]  data_q;
  logic [7:0]    byte_cnt_q;
  logic          data_valid_q;
  logic          frame_done_q;
  logic          frame_err_q;
`ifdef SPI_RECV_LEN_CHECK_EN
  logic          len_err_q;
`endif

  assign sclk_s    = sclk_sync_q[P_SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[P_SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[P_SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  // A full word is held for one cycle before it is published, giving the sync+2 latency.
  assign word_full = (bit_cnt_q == BW'(T));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: synchronizers reset to bus idle levels (SCLK low, SS high) so reset never reads as an edge.
      sclk_sync_q  <= '0;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      ss_prev_q    <= 1'b1;
      state_q      <= WAIT_IDLE;
      flush_cnt_q  <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      byte_cnt_q   <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SPI_RECV_LEN_CHECK_EN
      len_err_q    <= 1'b0;
`endif
    end else begin
      sclk_sync_q <= {sclk_sync_q[P_SYNC_STAGES-2:0], SPI0_SCLK_O};
      ss_sync_q   <= {ss_sync_q[P_SYNC_STAGES-2:0], SPI0_SS_O};
      mosi_sync_q <= {mosi_sync_q[P_SYNC_STAGES-2:0], SPI0_MOSI_O};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;

      // NOTE: strobes default low every cycle and are raised below, which keeps them one cycle wide.
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SPI_RECV_LEN_CHECK_EN
      len_err_q    <= 1'b0;
`endif

      case (state_q)
        WAIT_IDLE: begin
          // The preset synchronizer contents are not trusted until real pin samples reach the end.
          if (flush_cnt_q == FW'(P_SYNC_STAGES)) begin
            if (ss_s) state_q <= IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q + FW'(1);
          end
        end

        IDLE: begin
          if (ss_fall) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            state_q    <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (word_full) begin
            data_q       <= shreg_q;
            data_valid_q <= 1'b1;
            bit_cnt_q    <= '0;
            if (byte_cnt_q != 8'hFF) byte_cnt_q <= byte_cnt_q + 8'd1;
          end else if (sclk_rise && !ss_rise) begin
            shreg_q   <= (shreg_q << W) | T'(mosi_s);
            bit_cnt_q <= bit_cnt_q + BW'(W);
          end
          if (ss_rise) state_q <= CLOSE;
        end

        CLOSE: begin
          frame_done_q <= 1'b1;
          frame_err_q  <= (bit_cnt_q != '0);
`ifdef SPI_RECV_LEN_CHECK_EN
          len_err_q    <= (byte_cnt_q != 8'(P_FRAME_LEN)) || (bit_cnt_q != '0);
`endif
          bit_cnt_q    <= '0;
          state_q      <= IDLE;
        end

        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign data_o     = data_q;
  assign data_valid = data_valid_q;
  assign byte_cnt   = byte_cnt_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
`ifdef SPI_RECV_LEN_CHECK_EN
  assign len_err    = len_err_q;
`endif

endmodule

// File: tb/tb_spi_recv.sv
// tb_spi_recv: self-checking bench for spi_recv; table vectors, hand sequences and random frames
// checked against a bit-stream reference model.
module tb_spi_recv;

  localparam int SYNC      = 2;
  localparam int FRAME_LEN = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       ss    = 1'b1;
  logic [0:0] mosi  = 1'b0;
  logic [7:0] data_o;
  logic [7:0] byte_cnt;
  logic       data_valid;
  logic       frame_done;
  logic       frame_err;
  logic       len_err;

  always #5 clk = ~clk;

  spi_recv #(
    .P_DATA_IN_WIDTH  (1),
    .P_DATA_TEMP_WIDTH(8),
    .P_FRAME_LEN      (FRAME_LEN),
    .P_SYNC_STAGES    (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SPI0_SCLK_O(sclk),
    .SPI0_MOSI_O(mosi),
    .SPI0_SS_O  (ss),
    .data_o     (data_o),
    .data_valid (data_valid),
    .byte_cnt   (byte_cnt),
    .frame_done (frame_done),
    .frame_err  (frame_err)
`ifdef SPI_RECV_LEN_CHECK_EN
    ,
    .len_err    (len_err)
`endif
  );

`ifndef SPI_RECV_LEN_CHECK_EN
  assign len_err = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: captures strobed outputs on the falling edge.
  logic [7:0] act_data[$];
  logic [7:0] act_dvbc[$];
  logic       act_fd_err[$];
  logic [7:0] act_fd_bc[$];
  logic       act_fd_len[$];
  int         stray_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        act_data.push_back(data_o);
        act_dvbc.push_back(byte_cnt);
      end
      if (frame_done) begin
        act_fd_err.push_back(frame_err);
        act_fd_bc.push_back(byte_cnt);
        act_fd_len.push_back(len_err);
      end
      if (frame_err && !frame_done) stray_err++;
    end
  end

  // Reference model: the bits clocked in while SS is low, grouped into bytes at frame end.
  logic       cur_bits[$];
  bit         model_ignore = 1'b0;
  logic [7:0] exp_data[$];
  logic [7:0] exp_dvbc[$];
  logic       exp_fd_err[$];
  logic [7:0] exp_fd_bc[$];
  logic       exp_fd_len[$];

  function automatic void model_close();
    int nfull = cur_bits.size() / 8;
    int nsat  = (nfull > 255) ? 255 : nfull;
    bit part  = (cur_bits.size() % 8) != 0;
    for (int k = 0; k < nfull; k++) begin
      int w = 0;
      for (int j = 0; j < 8; j++) w = w * 2 + (cur_bits[8*k+j] ? 1 : 0);
      exp_data.push_back(8'(w));
      exp_dvbc.push_back(8'((k + 1 > 255) ? 255 : k + 1));
    end
    exp_fd_err.push_back(part);
    exp_fd_bc.push_back(8'(nsat));
    exp_fd_len.push_back((nsat != FRAME_LEN) || part);
    cur_bits.delete();
  endfunction

  task automatic compare_group(input string name);
    int nd = (act_data.size() < exp_data.size()) ? act_data.size() : exp_data.size();
    int nf = (act_fd_err.size() < exp_fd_err.size()) ? act_fd_err.size() : exp_fd_err.size();
    check($sformatf("%s.dv_count", name), act_data.size(), exp_data.size());
    for (int i = 0; i < nd; i++) begin
      check($sformatf("%s.data[%0d]", name, i), act_data[i], exp_data[i]);
      check($sformatf("%s.dv_byte_cnt[%0d]", name, i), act_dvbc[i], exp_dvbc[i]);
    end
    check($sformatf("%s.frame_done_count", name), act_fd_err.size(), exp_fd_err.size());
    for (int i = 0; i < nf; i++) begin
      check($sformatf("%s.frame_err[%0d]", name, i), act_fd_err[i], exp_fd_err[i]);
      check($sformatf("%s.frame_byte_cnt[%0d]", name, i), act_fd_bc[i], exp_fd_bc[i]);
`ifdef SPI_RECV_LEN_CHECK_EN
      check($sformatf("%s.len_err[%0d]", name, i), act_fd_len[i], exp_fd_len[i]);
`endif
    end
    check($sformatf("%s.stray_frame_err", name), stray_err, 0);
    clear_queues();
  endtask

  task automatic clear_queues();
    act_data.delete(); act_dvbc.delete(); act_fd_err.delete(); act_fd_bc.delete(); act_fd_len.delete();
    exp_data.delete(); exp_dvbc.delete(); exp_fd_err.delete(); exp_fd_bc.delete(); exp_fd_len.delete();
    stray_err = 0;
  endtask

  // Pin drivers: inputs change 1 ns after the rising clk edge.
  int half = 5;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    tick(half);
    sclk = 1'b1;
    if (!model_ignore) cur_bits.push_back(b);
    tick(half);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[7-i]);
  endtask

  task automatic frame_start();
    ss = 1'b0;
    tick(half);
  endtask

  task automatic frame_end(input int gap);
    tick(half);
    ss = 1'b1;
    if (!model_ignore) model_close();
    model_ignore = 1'b0;
    tick(gap);
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic [7:0]  tail;
    logic [2:0]  tail_bits;
    logic [2:0]  exp_dv;
    logic [7:0]  exp_last;
    logic [7:0]  exp_bc;
    logic        exp_err;
    logic        exp_len;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] tv_data;
  int          lat;

  initial begin
    #600us;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hA53CFF00, 3'd3, 8'h00, 3'd0, 3'd3, 8'hFF, 8'd3, 1'b0, 1'b0};
    vecs[1] = '{32'h12000000, 3'd1, 8'hC3, 3'd5, 3'd1, 8'h12, 8'd1, 1'b1, 1'b1};
    vecs[2] = '{32'h5A810000, 3'd2, 8'h00, 3'd0, 3'd2, 8'h81, 8'd2, 1'b0, 1'b1};
    vecs[3] = '{32'hDEADBEEF, 3'd4, 8'h00, 3'd0, 3'd4, 8'hEF, 8'd4, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 3'd0, 8'h00, 3'd0, 3'd0, 8'hEF, 8'd0, 1'b0, 1'b1};

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check("reset.data_o", data_o, 0);
    check("reset.data_valid", data_valid, 0);
    check("reset.byte_cnt", byte_cnt, 0);
    check("reset.frame_done", frame_done, 0);
    check("reset.frame_err", frame_err, 0);
`ifdef SPI_RECV_LEN_CHECK_EN
    check("reset.len_err", len_err, 0);
`endif
    rst_n = 1'b1;
    tick(6);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      half = 5;
      tv_data = vecs[v].data;
      frame_start();
      for (int i = 0; i < int'(vecs[v].nbytes); i++) send_bits(tv_data[31-8*i -: 8], 8);
      send_bits(vecs[v].tail, int'(vecs[v].tail_bits));
      frame_end(10);
      check($sformatf("vec%0d.dv_count", v), act_data.size(), int'(vecs[v].exp_dv));
      for (int i = 0; i < int'(vecs[v].exp_dv) && i < act_data.size(); i++)
        check($sformatf("vec%0d.byte[%0d]", v, i), act_data[i], tv_data[31-8*i -: 8]);
      check($sformatf("vec%0d.data_o", v), data_o, vecs[v].exp_last);
      check($sformatf("vec%0d.byte_cnt", v), byte_cnt, vecs[v].exp_bc);
      check($sformatf("vec%0d.frame_done_count", v), act_fd_err.size(), 1);
      if (act_fd_err.size() > 0) begin
        check($sformatf("vec%0d.frame_err", v), act_fd_err[0], vecs[v].exp_err);
`ifdef SPI_RECV_LEN_CHECK_EN
        check($sformatf("vec%0d.len_err", v), act_fd_len[0], vecs[v].exp_len);
`endif
      end
      compare_group($sformatf("vec%0d", v));
    end

    // SCLK activity while SS is high must be ignored
    frame_start();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    frame_end(10);
    compare_group("pre_idle");
    for (int i = 0; i < 16; i++) begin
      mosi = 1'(i & 1);
      tick(5);
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
    tick(10);
    check("idle_sclk.dv_count", act_data.size(), 0);
    check("idle_sclk.frame_done_count", act_fd_err.size(), 0);
    check("idle_sclk.byte_cnt", byte_cnt, 8'd2);
    check("idle_sclk.data_o", data_o, 8'h22);
    clear_queues();

    // Reset in the middle of byte 2 with SS held low
    frame_start();
    send_bits(8'h11, 8);
    send_bits(8'h2C, 3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("mid_reset.data_o", data_o, 0);
    check("mid_reset.data_valid", data_valid, 0);
    check("mid_reset.byte_cnt", byte_cnt, 0);
    check("mid_reset.frame_done", frame_done, 0);
    check("mid_reset.frame_err", frame_err, 0);
    clear_queues();
    cur_bits.delete();
    model_ignore = 1'b1;
    send_bits(8'h60, 5);
    send_bits(8'h33, 8);
    frame_end(10);
    check("after_reset.dv_count", act_data.size(), 0);
    check("after_reset.frame_done_count", act_fd_err.size(), 0);
    frame_start();
    send_bits(8'h5A, 8);
    frame_end(10);
    check("post_reset.data_o", data_o, 8'h5A);
    check("post_reset.byte_cnt", byte_cnt, 8'd1);
    compare_group("post_reset");

    // Back-to-back frames with a 3-clk SS gap
    frame_start();
    send_bits(8'h01, 8); send_bits(8'h02, 8); send_bits(8'h03, 8);
    frame_end(3);
    frame_start();
    send_bits(8'h80, 8); send_bits(8'h7F, 8); send_bits(8'h00, 8);
    frame_end(10);
    check("b2b.dv_count", act_data.size(), 6);
    check("b2b.frame_done_count", act_fd_bc.size(), 2);
    check("b2b.byte_cnt", byte_cnt, 8'd3);
    compare_group("b2b");

    // Latency from the last pin-level SCLK rise to data_valid
    frame_start();
    send_bits(8'h96, 7);
    mosi = 1'b0;
    tick(half);
    sclk = 1'b1;
    cur_bits.push_back(1'b0);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      if (data_valid && lat < 0) lat = c;
    end
    sclk = 1'b0;
    frame_end(10);
    check("latency", lat, SYNC + 2);
    compare_group("latency");

    // byte_cnt saturation
    half = 3;
    frame_start();
    for (int k = 0; k < 256; k++) send_bits(8'(k * 37 + 5), 8);
    frame_end(10);
    check("saturate.byte_cnt", byte_cnt, 8'd255);
    compare_group("saturate");

    // Random frames against the model
    for (int f = 0; f < 12; f++) begin
      half = $urandom_range(3, 6);
      frame_start();
      for (int b = $urandom_range(0, 4); b > 0; b--) send_bits(8'($urandom_range(0, 255)), 8);
      if ($urandom_range(0, 3) == 0) send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7));
      frame_end($urandom_range(3, 8));
    end
    tick(10);
    compare_group("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
